// File: rtl/mcalu_pkg.sv
// Shared opcode constants, FSM state type and opcode helpers for the multi-cycle ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mcalu_pkg;

  typedef logic [4:0] op_t;

  // Simple (single-cycle) opcodes, shared with the scalu units.
  localparam op_t OP_ADD  = 5'b00000;
  localparam op_t OP_SLL  = 5'b00001;
  localparam op_t OP_SLT  = 5'b00010;
  localparam op_t OP_SLTU = 5'b00011;
  localparam op_t OP_XOR  = 5'b00100;
  localparam op_t OP_SRL  = 5'b00101;
  localparam op_t OP_OR   = 5'b00110;
  localparam op_t OP_AND  = 5'b00111;
  localparam op_t OP_SUB  = 5'b01000;
  localparam op_t OP_SRA  = 5'b01101;

  // Multi-cycle sub-opcodes (op[2:0] when op[4:3] == 2'b11).
  localparam logic [2:0] MC_MUL    = 3'b000;
  localparam logic [2:0] MC_MULH   = 3'b001;
  localparam logic [2:0] MC_MULHSU = 3'b010;
  localparam logic [2:0] MC_MULHU  = 3'b011;
  localparam logic [2:0] MC_DIV    = 3'b100;
  localparam logic [2:0] MC_DIVU   = 3'b101;
  localparam logic [2:0] MC_REM    = 3'b110;
  localparam logic [2:0] MC_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_multi(input op_t op);
    return op[4:3] == 2'b11;
  endfunction

endpackage

// File: rtl/mcalu_if.sv
// Issue / writeback / flush bundle between the reservation station, ROB, writeback arbiter and the unit.
// Latency: n/a (wires only).
// Backpressure: mcalu_stall towards the issuer, wb_mcalu_stall from the writeback arbiter.
interface mcalu_if;
  import mcalu_pkg::*;

  logic        exers_mcalu_issue;
  op_t         exers_mcalu_op;
  logic [6:0]  exers_robid;
  logic [5:0]  exers_rd;
  logic [31:0] exers_op1;
  logic [31:0] exers_op2;
  logic        mcalu_stall;
  logic        mcalu_valid;
  logic [6:0]  mcalu_robid;
  logic [5:0]  mcalu_rd;
  logic [31:0] mcalu_result;
  logic        wb_mcalu_stall;
  logic        rob_flush;

  // Issuer / arbiter / ROB side.
  modport master (
    output exers_mcalu_issue, exers_mcalu_op, exers_robid, exers_rd, exers_op1, exers_op2,
    output wb_mcalu_stall, rob_flush,
    input  mcalu_stall, mcalu_valid, mcalu_robid, mcalu_rd, mcalu_result
  );

  // Execution unit side.
  modport slave (
    input  exers_mcalu_issue, exers_mcalu_op, exers_robid, exers_rd, exers_op1, exers_op2,
    input  wb_mcalu_stall, rob_flush,
    output mcalu_stall, mcalu_valid, mcalu_robid, mcalu_rd, mcalu_result
  );

endinterface

// File: rtl/mcalu_scalu_core.sv
// Combinational simple-op ALU shared by the scalu units and the mcalu single-cycle path.
// Latency: purely combinational.
// Backpressure: none; undefined opcodes yield zero.
module scalu_core
  import mcalu_pkg::*;
(
  input  op_t         op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  // Decode the opcode and select the result; anything unlisted returns 0.
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_SLL:  y = a << b[4:0];
      OP_SRL:  y = a >> b[4:0];
      OP_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      OP_SLT:  y = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: y = {31'd0, a < b};
      OP_XOR:  y = a ^ b;
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mcalu.sv
// Multi-cycle ALU: simple ops in one cycle, RV32M mul/div via a 32-step shift datapath.
// Latency: valid 1 cycle after issue for simple ops, 34 cycles for mul/div.
// Backpressure: stall high whenever not IDLE; result held in DONE until wb_mcalu_stall drops.
module mcalu
  import mcalu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  mcalu_if.slave bus
);

  state_t      state, state_n;
  logic [4:0]  cnt;
  logic [2:0]  mop_q;
  logic [31:0] hi, lo, opnd, op1_q;
  logic        neg_q, rneg_q, dz_q;
  logic [6:0]  robid_q;
  logic [5:0]  rd_q;
  logic [31:0] result_q;

  logic        accept;
  logic        sgn_a, sgn_b, a_neg, b_neg, is_div;
  logic [31:0] mag_a, mag_b, alu_y;
  logic [32:0] mul_sum, div_sh, div_rem;
  logic        div_ge;
  logic [63:0] prod_s;
  logic [31:0] fix_res;

  scalu_core u_scalu (
    .op (bus.exers_mcalu_op),
    .a  (bus.exers_op1),
    .b  (bus.exers_op2),
    .y  (alu_y)
  );

  assign accept = (state == ST_IDLE) && bus.exers_mcalu_issue && !bus.rob_flush;
  assign is_div = bus.exers_mcalu_op[2];

  assign bus.mcalu_stall  = (state != ST_IDLE);
  assign bus.mcalu_valid  = (state == ST_DONE);
  assign bus.mcalu_robid  = robid_q;
  assign bus.mcalu_rd     = rd_q;
  assign bus.mcalu_result = result_q;

  // Which operands are signed for the op being issued, and their magnitudes.
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (bus.exers_mcalu_op[2:0])
      MC_MULH, MC_DIV, MC_REM: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      MC_MULHSU: sgn_a = 1'b1;
      default: ;
    endcase
    a_neg = sgn_a & bus.exers_op1[31];
    b_neg = sgn_b & bus.exers_op2[31];
    mag_a = a_neg ? (32'd0 - bus.exers_op1) : bus.exers_op1;
    mag_b = b_neg ? (32'd0 - bus.exers_op2) : bus.exers_op2;
  end

  // One iteration of shift-add multiply and restoring divide on the shared hi/lo pair.
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : 33'd0);
    div_sh  = {hi, lo[31]};
    div_ge  = div_sh >= {1'b0, opnd};
    div_rem = div_ge ? (div_sh - {1'b0, opnd}) : div_sh;
  end

  // Sign correction and divide-by-zero substitution applied in FIX.
  always_comb begin
    prod_s  = neg_q ? (64'd0 - {hi, lo}) : {hi, lo};
    fix_res = '0;
    case (mop_q)
      MC_MUL:                       fix_res = prod_s[31:0];
      MC_MULH, MC_MULHSU, MC_MULHU: fix_res = prod_s[63:32];
      MC_DIV, MC_DIVU:              fix_res = dz_q ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - lo) : lo);
      default:                      fix_res = dz_q ? op1_q : (rneg_q ? (32'd0 - hi) : hi);
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state logic; a flush overrides everything, including a same-cycle issue or writeback.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (bus.exers_mcalu_issue)
                 state_n = is_multi(bus.exers_mcalu_op) ? ST_BUSY : ST_DONE;
      ST_BUSY: if (cnt == 5'd31) state_n = ST_FIX;
      ST_FIX:  state_n = ST_DONE;
      ST_DONE: if (!bus.wb_mcalu_stall) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (bus.rob_flush) state_n = ST_IDLE;
  end

  // Operand capture on issue, iteration in BUSY, result capture in FIX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      mop_q    <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      op1_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      robid_q  <= '0;
      rd_q     <= '0;
      result_q <= '0;
    end else if (accept) begin
      cnt     <= '0;
      mop_q   <= bus.exers_mcalu_op[2:0];
      robid_q <= bus.exers_robid;
      rd_q    <= bus.exers_rd;
      op1_q   <= bus.exers_op1;
      hi      <= '0;
      lo      <= is_div ? mag_a : mag_b;
      opnd    <= is_div ? mag_b : mag_a;
      neg_q   <= a_neg ^ b_neg;
      rneg_q  <= a_neg;
      dz_q    <= (bus.exers_op2 == 32'd0);
      if (!is_multi(bus.exers_mcalu_op)) result_q <= alu_y;
    end else if (state == ST_BUSY) begin
      cnt <= cnt + 5'd1;
      if (mop_q[2]) begin
        hi <= div_rem[31:0];
        lo <= {lo[30:0], div_ge};
      end else begin
        {hi, lo} <= {mul_sum, lo[31:1]};
      end
    end else if (state == ST_FIX) begin
      result_q <= fix_res;
    end
  end

endmodule

// File: tb/tb_mcalu.sv
// Randomized and directed bench for mcalu with a queue-based scoreboard and arithmetic reference model.
// Latency: checks 1-cycle simple ops and 34-cycle mul/div first-valid timing.
// Backpressure: exercises writeback stall, flush and async reset mid-operation.
module tb_mcalu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  mcalu_if bus();

  mcalu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [6:0]  robid;
    logic [5:0]  rd;
    logic [31:0] res;
    int          cyc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: RV32I simple ops and RV32M semantics computed with wide integer arithmetic.
  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] t;
    logic [31:0] r;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = 32'd0;
    case (op)
      5'b00000: r = a + b;
      5'b01000: r = a - b;
      5'b00001: r = a << b[4:0];
      5'b00101: r = a >> b[4:0];
      5'b01101: r = $unsigned($signed(a) >>> b[4:0]);
      5'b00010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'b00011: r = (a < b) ? 32'd1 : 32'd0;
      5'b00100: r = a ^ b;
      5'b00110: r = a | b;
      5'b00111: r = a & b;
      5'b11000: begin t = sa * sb; r = t[31:0]; end
      5'b11001: begin t = sa * sb; r = t[63:32]; end
      5'b11010: begin t = sa * ub; r = t[63:32]; end
      5'b11011: begin t = {32'd0, a} * {32'd0, b}; r = t[63:32]; end
      5'b11100: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (ovf)   r = a;
        else begin t = sa / sb; r = t[31:0]; end
      end
      5'b11101: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      5'b11110: begin
        if (b == 32'd0) r = a;
        else if (ovf)   r = 32'd0;
        else begin t = sa % sb; r = t[31:0]; end
      end
      5'b11111: r = (b == 32'd0) ? a : a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Present an issue on the interface and record what the unit must eventually write back.
  task automatic issue_exp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [6:0] rid, input logic [5:0] rd, input bit expect_wb);
    exp_t e;
    bus.exers_mcalu_issue = 1'b1;
    bus.exers_mcalu_op    = op;
    bus.exers_op1         = a;
    bus.exers_op2         = b;
    bus.exers_robid       = rid;
    bus.exers_rd          = rd;
    if (expect_wb) begin
      e.robid = rid;
      e.rd    = rd;
      e.res   = ref_alu(op, a, b);
      e.cyc   = cyc;
      e.lat   = (op[4:3] == 2'b11) ? 34 : 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!bus.mcalu_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("valid_timeout", {63'd0, bus.mcalu_valid}, 64'd1);
  endtask

  // Full transaction; entered and left at a negedge with the unit idle.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [6:0] rid, input logic [5:0] rd, input int nstall);
    issue_exp(op, a, b, rid, rd, 1'b1);
    @(negedge clk);
    bus.exers_mcalu_issue = 1'b0;
    chk("stall_after_issue", {63'd0, bus.mcalu_stall}, 64'd1);
    bus.wb_mcalu_stall = (nstall > 0);
    wait_valid();
    for (int i = 0; i < nstall; i++) begin
      chk("stall_in_done", {63'd0, bus.mcalu_stall}, 64'd1);
      @(negedge clk);
    end
    bus.wb_mcalu_stall = 1'b0;
    @(negedge clk);
    chk("idle_after_wb", {62'd0, bus.mcalu_stall, bus.mcalu_valid}, 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pop on each new writeback, then insist the payload holds while valid stays up.
  initial begin
    bit          prev_v = 1'b0;
    logic [44:0] held   = '0;
    exp_t        e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mcalu_valid) begin
        if (!prev_v) begin
          if (exp_q.size() == 0) begin
            chk("spurious_valid", {63'd0, bus.mcalu_valid}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("result", {32'd0, bus.mcalu_result}, {32'd0, e.res});
            chk("robid",  {57'd0, bus.mcalu_robid}, {57'd0, e.robid});
            chk("rd",     {58'd0, bus.mcalu_rd}, {58'd0, e.rd});
            chk("latency", 64'(cyc - e.cyc), 64'(e.lat));
          end
          held = {bus.mcalu_robid, bus.mcalu_rd, bus.mcalu_result};
        end else begin
          chk("payload_stable", {19'd0, bus.mcalu_robid, bus.mcalu_rd, bus.mcalu_result}, {19'd0, held});
        end
      end
      prev_v = bus.mcalu_valid;
    end
  end

  initial begin
    logic [4:0] ops [20] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                             5'b00110, 5'b00111, 5'b01000, 5'b01101, 5'b11000, 5'b11001,
                             5'b11010, 5'b11011, 5'b11100, 5'b11101, 5'b11110, 5'b11111,
                             5'b01001, 5'b10011};
    bus.exers_mcalu_issue = 1'b0;
    bus.exers_mcalu_op    = '0;
    bus.exers_robid       = '0;
    bus.exers_rd          = '0;
    bus.exers_op1         = '0;
    bus.exers_op2         = '0;
    bus.wb_mcalu_stall    = 1'b0;
    bus.rob_flush         = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_valid",  {63'd0, bus.mcalu_valid}, 64'd0);
    chk("rst_stall",  {63'd0, bus.mcalu_stall}, 64'd0);
    chk("rst_robid",  {57'd0, bus.mcalu_robid}, 64'd0);
    chk("rst_rd",     {58'd0, bus.mcalu_rd}, 64'd0);
    chk("rst_result", {32'd0, bus.mcalu_result}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed: simple op, multiplies, division boundaries, divide by zero.
    run_op(5'b00000, 32'd5, 32'd7, 7'd3, 6'd9, 0);
    run_op(5'b11000, 32'hFFFF_FFFF, 32'd3, 7'd10, 6'd1, 0);
    run_op(5'b11001, 32'hFFFF_FFFF, 32'd3, 7'd11, 6'd2, 0);
    run_op(5'b11011, 32'hFFFF_FFFF, 32'd3, 7'd12, 6'd3, 0);
    run_op(5'b11010, 32'hFFFF_FFFF, 32'd3, 7'd13, 6'd4, 0);
    run_op(5'b11100, 32'h8000_0000, 32'hFFFF_FFFF, 7'd14, 6'd5, 0);
    run_op(5'b11110, 32'h8000_0000, 32'hFFFF_FFFF, 7'd15, 6'd6, 0);
    run_op(5'b11100, 32'hFFFF_FFF9, 32'd2, 7'd16, 6'd7, 0);
    run_op(5'b11110, 32'hFFFF_FFF9, 32'd2, 7'd17, 6'd8, 0);
    run_op(5'b11101, 32'd7, 32'd0, 7'd18, 6'd33, 0);
    run_op(5'b11111, 32'd7, 32'd0, 7'd19, 6'd34, 0);
    run_op(5'b11100, 32'd7, 32'd0, 7'd20, 6'd35, 0);

    // Writeback stall for 3 cycles, then an immediate back-to-back issue.
    run_op(5'b01000, 32'd100, 32'd1, 7'd21, 6'd10, 3);
    run_op(5'b00110, 32'hF0F0_0000, 32'h0000_0F0F, 7'd22, 6'd11, 0);

    // Issue while busy must be ignored; the original op still completes correctly.
    issue_exp(5'b11101, 32'd1000, 32'd7, 7'd23, 6'd12, 1'b1);
    @(negedge clk);
    bus.exers_mcalu_issue = 1'b0;
    repeat (3) @(negedge clk);
    issue_exp(5'b00000, 32'd1, 32'd1, 7'd99, 6'd13, 1'b0);
    @(negedge clk);
    bus.exers_mcalu_issue = 1'b0;
    wait_valid();
    @(negedge clk);

    // Flush at BUSY iteration 10.
    issue_exp(5'b11100, 32'd12345, 32'd17, 7'd40, 6'd14, 1'b0);
    @(negedge clk);
    bus.exers_mcalu_issue = 1'b0;
    repeat (10) @(negedge clk);
    bus.rob_flush = 1'b1;
    @(negedge clk);
    bus.rob_flush = 1'b0;
    chk("flush_stall", {63'd0, bus.mcalu_stall}, 64'd0);
    repeat (40) @(negedge clk);

    // Issue in the same cycle as a flush is dropped.
    issue_exp(5'b00000, 32'd2, 32'd2, 7'd41, 6'd15, 1'b0);
    bus.rob_flush = 1'b1;
    @(negedge clk);
    bus.exers_mcalu_issue = 1'b0;
    bus.rob_flush = 1'b0;
    chk("flush_issue_drop", {62'd0, bus.mcalu_stall, bus.mcalu_valid}, 64'd0);

    // Flush coinciding with writeback acceptance still delivers the result.
    issue_exp(5'b00100, 32'hAAAA_5555, 32'hFFFF_0000, 7'd42, 6'd16, 1'b1);
    @(negedge clk);
    bus.exers_mcalu_issue = 1'b0;
    bus.rob_flush = 1'b1;
    @(negedge clk);
    bus.rob_flush = 1'b0;
    chk("flush_wb_idle", {62'd0, bus.mcalu_stall, bus.mcalu_valid}, 64'd0);

    // Asynchronous reset in the middle of BUSY.
    issue_exp(5'b11001, 32'h1234_5678, 32'h9ABC_DEF0, 7'd43, 6'd17, 1'b0);
    @(negedge clk);
    bus.exers_mcalu_issue = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_stall", {63'd0, bus.mcalu_stall}, 64'd0);
    chk("async_rst_result", {32'd0, bus.mcalu_result}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      run_op(ops[$urandom_range(0, 19)], pick_operand(), pick_operand(),
             7'($urandom_range(0, 127)), 6'($urandom_range(0, 63)), $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
